// File: rtl/io_block_transfer.sv
// Block transfer initiator between an 8-bit frame device and the memory I/O request/reply port.
// Load packs four frames into one 31-bit word per memory write; dump unpacks each read word into four frames.
module io_block_transfer #(
  parameter int REPLY_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start_from_pnl,
  input  logic        dir_from_pnl,
  input  logic        abort_from_pnl,
  input  logic [11:0] start_addr_from_pnl,
  input  logic [11:0] count_from_pnl,
  input  logic [7:0]  in_frame,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_frame,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        mem_write_to_mem,
  output logic        mem_read_to_mem,
  input  logic        mem_reply_from_mem,
  output logic [11:0] sel_value_to_sel,
  output logic        write_sign_to_mem,
  output logic [29:0] write_data_to_mem,
  input  logic        read_sign_from_mem,
  input  logic [29:0] read_data_from_mem,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IDLE, S_GET, S_WREQ, S_WWAIT, S_RREQ, S_RWAIT, S_PUT, S_FIN
  } state_t;

  state_t      state, state_nxt;
  logic [11:0] cnt;
  logic [31:0] word;
  logic [1:0]  frm_cnt;
  logic [7:0]  tmo_cnt;
  logic        abort_pend;
  logic        in_fire, out_fire, tmo_hit;

  // One shift register serves both directions: frames enter at the top, leave at the bottom.
  assign write_sign_to_mem = word[30];
  assign write_data_to_mem = word[29:0];
  assign out_frame         = word[7:0];

  assign in_fire  = in_ready && in_valid;
  assign out_fire = out_valid && out_ready;
  assign tmo_hit  = !mem_reply_from_mem && (tmo_cnt == 8'(REPLY_TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (start_from_pnl && !abort_from_pnl) begin
          if (count_from_pnl == 12'd0) state_nxt = S_FIN;
          else                         state_nxt = dir_from_pnl ? S_RREQ : S_GET;
        end
      end
      S_GET: begin
        if (abort_from_pnl)                   state_nxt = S_IDLE;
        else if (in_fire && frm_cnt == 2'd3)  state_nxt = S_WREQ;
      end
      S_WREQ: state_nxt = S_WWAIT;
      S_WWAIT: begin
        if (mem_reply_from_mem) begin
          if (abort_pend || abort_from_pnl) state_nxt = S_IDLE;
          else                              state_nxt = (cnt == 12'd1) ? S_FIN : S_GET;
        end else if (tmo_hit) begin
          state_nxt = S_IDLE;
        end
      end
      S_RREQ: state_nxt = S_RWAIT;
      S_RWAIT: begin
        if (mem_reply_from_mem) state_nxt = (abort_pend || abort_from_pnl) ? S_IDLE : S_PUT;
        else if (tmo_hit)       state_nxt = S_IDLE;
      end
      S_PUT: begin
        if (abort_from_pnl)                    state_nxt = S_IDLE;
        else if (out_fire && frm_cnt == 2'd3)  state_nxt = (cnt == 12'd0) ? S_FIN : S_RREQ;
      end
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Handshake and request outputs are registered from the next state so they align with it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state            <= S_IDLE;
      busy             <= 1'b0;
      in_ready         <= 1'b0;
      out_valid        <= 1'b0;
      mem_write_to_mem <= 1'b0;
      mem_read_to_mem  <= 1'b0;
      done             <= 1'b0;
      error            <= 1'b0;
      sel_value_to_sel <= '0;
      cnt              <= '0;
      word             <= '0;
      frm_cnt          <= '0;
      tmo_cnt          <= '0;
      abort_pend       <= 1'b0;
    end else begin
      state            <= state_nxt;
      busy             <= (state_nxt != S_IDLE);
      in_ready         <= (state_nxt == S_GET);
      out_valid        <= (state_nxt == S_PUT);
      mem_write_to_mem <= (state_nxt == S_WREQ);
      mem_read_to_mem  <= (state_nxt == S_RREQ);
      done             <= (state == S_FIN);

      unique case (state)
        S_IDLE: begin
          if (start_from_pnl && !abort_from_pnl) begin
            sel_value_to_sel <= start_addr_from_pnl;
            cnt              <= count_from_pnl;
            error            <= 1'b0;
            abort_pend       <= 1'b0;
            frm_cnt          <= '0;
          end
        end
        S_GET: begin
          if (abort_from_pnl) begin
            frm_cnt <= '0;
          end else if (in_fire) begin
            word    <= {in_frame, word[31:8]};
            frm_cnt <= frm_cnt + 2'd1;
          end
        end
        S_WREQ, S_RREQ: begin
          tmo_cnt <= 8'd1;
          if (abort_from_pnl) abort_pend <= 1'b1;
        end
        S_WWAIT, S_RWAIT: begin
          if (abort_from_pnl) abort_pend <= 1'b1;
          tmo_cnt <= tmo_cnt + 8'd1;
          if (mem_reply_from_mem) begin
            sel_value_to_sel <= sel_value_to_sel + 12'd1;
            cnt              <= cnt - 12'd1;
            if (state == S_RWAIT) word <= {1'b0, read_sign_from_mem, read_data_from_mem};
          end else if (tmo_hit) begin
            error <= 1'b1;
          end
        end
        S_PUT: begin
          if (abort_from_pnl) begin
            frm_cnt <= '0;
          end else if (out_fire) begin
            word    <= {8'h00, word[31:8]};
            frm_cnt <= frm_cnt + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_io_block_transfer.sv
// Self-checking bench for io_block_transfer: frame source/sink and memory models,
// reference results computed from frame packing and address arithmetic.
module tb_io_block_transfer;
  localparam int TMO = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn, start_from_pnl, dir_from_pnl, abort_from_pnl;
  logic [11:0] start_addr_from_pnl, count_from_pnl;
  logic [7:0]  in_frame, out_frame;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic        mem_write_to_mem, mem_read_to_mem, mem_reply_from_mem;
  logic [11:0] sel_value_to_sel;
  logic        write_sign_to_mem, read_sign_from_mem;
  logic [29:0] write_data_to_mem, read_data_from_mem;
  logic        busy, done, error;

  io_block_transfer #(.REPLY_TIMEOUT(TMO)) dut (
    .clk(clk), .resetn(resetn),
    .start_from_pnl(start_from_pnl), .dir_from_pnl(dir_from_pnl),
    .abort_from_pnl(abort_from_pnl), .start_addr_from_pnl(start_addr_from_pnl),
    .count_from_pnl(count_from_pnl),
    .in_frame(in_frame), .in_valid(in_valid), .in_ready(in_ready),
    .out_frame(out_frame), .out_valid(out_valid), .out_ready(out_ready),
    .mem_write_to_mem(mem_write_to_mem), .mem_read_to_mem(mem_read_to_mem),
    .mem_reply_from_mem(mem_reply_from_mem), .sel_value_to_sel(sel_value_to_sel),
    .write_sign_to_mem(write_sign_to_mem), .write_data_to_mem(write_data_to_mem),
    .read_sign_from_mem(read_sign_from_mem), .read_data_from_mem(read_data_from_mem),
    .busy(busy), .done(done), .error(error)
  );

  typedef struct packed { logic [11:0] a; logic [30:0] w; } wr_t;

  int n_checks = 0, n_pass = 0;
  int done_cnt = 0, req_cnt = 0, prot_err = 0;
  int vld_pct = 100, rdy_pct = 100, hold_ready = 0;
  bit mem_alive = 1'b1;
  logic [30:0] mem [4096];
  wr_t         wq[$];
  logic [7:0]  srcq[$], rxq[$], frm[$];

  // Memory model: reply two cycles after each request, records writes, serves reads.
  logic [1:0]  p_req, p_wr;
  logic [11:0] h_addr;
  logic [30:0] h_word;
  logic        h_wr, req;
  initial begin
    mem_reply_from_mem = 1'b0; read_sign_from_mem = 1'b0; read_data_from_mem = '0;
    p_req = '0; p_wr = '0; h_addr = '0; h_word = '0; h_wr = 1'b0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        p_req = '0; p_wr = '0; mem_reply_from_mem = 1'b0;
      end else begin
        if (done) done_cnt++;
        req = mem_write_to_mem | mem_read_to_mem;
        if (mem_write_to_mem && mem_read_to_mem) prot_err++;
        if (req && (p_req != 2'b00)) prot_err++;
        if (p_req != 2'b00)
          if (sel_value_to_sel !== h_addr ||
              (h_wr && {write_sign_to_mem, write_data_to_mem} !== h_word)) prot_err++;
        mem_reply_from_mem = mem_alive && p_req[1];
        if (mem_reply_from_mem && !p_wr[1]) {read_sign_from_mem, read_data_from_mem} = mem[h_addr];
        if (req) begin
          req_cnt++;
          h_addr = sel_value_to_sel;
          h_wr   = mem_write_to_mem;
          h_word = {write_sign_to_mem, write_data_to_mem};
          if (mem_write_to_mem) begin
            wq.push_back('{h_addr, h_word});
            mem[h_addr] = h_word;
          end
        end
        p_req = {p_req[0], req};
        p_wr  = {p_wr[0], mem_write_to_mem};
      end
    end
  end

  // Frame source.
  logic li_r;
  initial begin
    in_valid = 1'b0; in_frame = '0; li_r = 1'b0;
    forever begin
      @(negedge clk);
      if (in_valid && li_r && srcq.size() > 0) void'(srcq.pop_front());
      if (srcq.size() > 0 && $urandom_range(99, 0) < vld_pct) begin
        in_valid = 1'b1; in_frame = srcq[0];
      end else begin
        in_valid = 1'b0; in_frame = 8'($urandom);
      end
      li_r = in_ready;
    end
  end

  // Frame sink; a frame left unaccepted must not change while still offered.
  logic lo_v, lo_r;
  logic [7:0] lo_f;
  initial begin
    out_ready = 1'b0; lo_v = 1'b0; lo_r = 1'b0; lo_f = '0;
    forever begin
      @(negedge clk);
      if (lo_v && lo_r) rxq.push_back(lo_f);
      if (lo_v && !lo_r && out_valid && out_frame !== lo_f) prot_err++;
      if (hold_ready > 0) begin
        out_ready = 1'b0;
        if (out_valid) hold_ready--;
      end else begin
        out_ready = ($urandom_range(99, 0) < rdy_pct);
      end
      lo_v = out_valid; lo_f = out_frame; lo_r = out_ready;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic pulse_start(input logic d, input logic [11:0] a, input logic [11:0] c);
    dir_from_pnl = d; start_addr_from_pnl = a; count_from_pnl = c; start_from_pnl = 1'b1;
    tick();
    start_from_pnl = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (!busy) begin ok = 1'b1; break; end
    end
    check({tag, "_idle"}, 64'(ok), 64'd1);
  endtask

  task automatic wait_req(input bit wr, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (wr ? mem_write_to_mem : mem_read_to_mem) begin ok = 1'b1; break; end
    end
    check({tag, "_req"}, 64'(ok), 64'd1);
  endtask

  // Expected writes: word i is frames 4i..4i+3 little-endian, bit 31 dropped, at start+i mod 4096.
  task automatic run_load(input logic [11:0] a, input int n, input string tag);
    int d0;
    logic [31:0] w;
    wq.delete(); srcq = frm; d0 = done_cnt; prot_err = 0;
    pulse_start(1'b0, a, 12'(n));
    pulse_start(1'b1, a ^ 12'h555, 12'd7);
    wait_idle(80 * n + 40, tag);
    check({tag, "_nwr"}, 64'(wq.size()), 64'(n));
    for (int i = 0; i < n && i < wq.size(); i++) begin
      w = {frm[4*i+3], frm[4*i+2], frm[4*i+1], frm[4*i]};
      check({tag, "_addr"}, 64'(wq[i].a), 64'((int'(a) + i) % 4096));
      check({tag, "_word"}, 64'(wq[i].w), 64'(w[30:0]));
    end
    tick();
    check({tag, "_done"}, 64'(done_cnt - d0), 64'd1);
    check({tag, "_err"}, 64'({error, busy}), 64'd0);
    check({tag, "_proto"}, 64'(prot_err), 64'd0);
  endtask

  // Expected frames: each word read from start+i, zero-extended to 32 bits, emitted low byte first.
  task automatic run_dump(input logic [11:0] a, input int n, input string tag);
    int d0;
    logic [31:0] w;
    rxq.delete(); d0 = done_cnt; prot_err = 0;
    pulse_start(1'b1, a, 12'(n));
    pulse_start(1'b0, a ^ 12'h2AA, 12'd5);
    wait_idle(80 * n + 40, tag);
    check({tag, "_nfrm"}, 64'(rxq.size()), 64'(4 * n));
    for (int i = 0; i < n; i++) begin
      w = {1'b0, mem[(int'(a) + i) % 4096]};
      for (int j = 0; j < 4; j++)
        if (4 * i + j < rxq.size()) check({tag, "_frame"}, 64'(rxq[4*i+j]), 64'(w[8*j +: 8]));
    end
    tick();
    check({tag, "_done"}, 64'(done_cnt - d0), 64'd1);
    check({tag, "_err"}, 64'({error, busy}), 64'd0);
    check({tag, "_proto"}, 64'(prot_err), 64'd0);
  endtask

  initial begin
    int d0, r0, k, n;
    logic [11:0] a;
    logic [7:0] exp_f [4];
    wr_t wr0, wr1;

    resetn = 1'b0; start_from_pnl = 1'b0; dir_from_pnl = 1'b0; abort_from_pnl = 1'b0;
    start_addr_from_pnl = '0; count_from_pnl = '0;
    for (int i = 0; i < 4096; i++) mem[i] = 31'($urandom);
    tick(); tick();
    check("reset_ctl", 64'({busy, done, error, in_ready, out_valid, mem_write_to_mem,
                           mem_read_to_mem, write_sign_to_mem, out_frame, sel_value_to_sel}), 64'd0);
    check("reset_data", 64'(write_data_to_mem), 64'd0);
    resetn = 1'b1;
    tick();

    // Directed load of two words ending at the top of memory.
    frm = '{8'h44, 8'h33, 8'h22, 8'h11, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    run_load(12'o7776, 2, "load2");
    wr0 = '{12'o7776, {1'b0, 30'h1122_3344}};
    wr1 = '{12'o7777, {1'b1, 30'h3FFF_FFFF}};
    if (wq.size() == 2) begin
      check("load2_w0", 64'(wq[0]), 64'(wr0));
      check("load2_w1", 64'(wq[1]), 64'(wr1));
    end

    // Directed dump with the sink stalling on the first frame.
    mem[12'o0123] = {1'b1, 30'h0ABC_DEF0};
    exp_f = '{8'hF0, 8'hDE, 8'hBC, 8'h4A};
    hold_ready = 3;
    run_dump(12'o0123, 1, "dump1");
    for (int j = 0; j < 4; j++)
      if (j < rxq.size()) check("dump1_lit", 64'(rxq[j]), 64'(exp_f[j]));

    // Address wrap.
    frm.delete();
    for (int i = 0; i < 8; i++) frm.push_back(8'($urandom));
    run_load(12'o7777, 2, "wrap");

    // Zero count: only FIN, no memory traffic.
    d0 = done_cnt; r0 = req_cnt;
    pulse_start(1'b0, 12'o0100, 12'd0);
    check("cnt0_s1", 64'({busy, done}), 64'b10);
    tick();
    check("cnt0_s2", 64'({busy, done}), 64'b01);
    tick();
    check("cnt0_req", 64'(req_cnt - r0), 64'd0);
    check("cnt0_done", 64'(done_cnt - d0), 64'd1);

    // Reply timeout on a write.
    mem_alive = 1'b0; d0 = done_cnt;
    srcq = '{8'h01, 8'h02, 8'h03, 8'h04};
    pulse_start(1'b0, 12'o0200, 12'd1);
    wait_req(1'b1, "tmo");
    k = 0;
    for (int i = 0; i < 300; i++) begin
      tick(); k++;
      if (error) break;
    end
    check("tmo_cycles", 64'(k), 64'(TMO));
    check("tmo_busy", 64'(busy), 64'd0);
    mem_alive = 1'b1;
    tick(); tick(); tick();
    check("tmo_nodone", 64'(done_cnt - d0), 64'd0);
    pulse_start(1'b0, 12'o0300, 12'd0);
    check("tmo_clear", 64'(error), 64'd0);
    tick(); tick();

    // Abort while waiting for a write reply.
    d0 = done_cnt; wq.delete();
    srcq = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    pulse_start(1'b0, 12'o0400, 12'd2);
    wait_req(1'b1, "abw");
    tick();
    abort_from_pnl = 1'b1;
    tick();
    abort_from_pnl = 1'b0;
    check("abw_wait", 64'(busy), 64'd1);
    tick();
    check("abw_idle", 64'(busy), 64'd0);
    for (int i = 0; i < 10; i++) tick();
    check("abw_nwr", 64'(wq.size()), 64'd1);
    check("abw_nodone", 64'(done_cnt - d0), 64'd0);

    // Abort in GET after two frames.
    d0 = done_cnt; wq.delete(); srcq.delete();
    pulse_start(1'b0, 12'o0500, 12'd1);
    srcq = '{8'h5A, 8'hA5};
    k = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (srcq.size() == 0) begin k = 1; break; end
    end
    check("abg_frames", 64'(k), 64'd1);
    abort_from_pnl = 1'b1;
    tick();
    abort_from_pnl = 1'b0;
    check("abg_idle", 64'({busy, in_ready}), 64'd0);
    for (int i = 0; i < 6; i++) tick();
    check("abg_nwr", 64'(wq.size()), 64'd0);
    check("abg_nodone", 64'(done_cnt - d0), 64'd0);

    // Abort and start together in IDLE.
    r0 = req_cnt;
    abort_from_pnl = 1'b1;
    pulse_start(1'b1, 12'o0600, 12'd2);
    abort_from_pnl = 1'b0;
    tick();
    check("abst_idle", 64'(busy), 64'd0);
    check("abst_req", 64'(req_cnt - r0), 64'd0);

    // Randomised transfers.
    for (int it = 0; it < 8; it++) begin
      vld_pct = $urandom_range(100, 30);
      rdy_pct = $urandom_range(100, 30);
      n = $urandom_range(5, 1);
      a = (it % 4 == 3) ? 12'hFFE : 12'($urandom);
      if (it % 2 == 0) begin
        frm.delete();
        for (int i = 0; i < 4 * n; i++) frm.push_back(8'($urandom));
        run_load(a, n, "rnd_load");
      end else begin
        for (int i = 0; i < n; i++) mem[(int'(a) + i) % 4096] = 31'($urandom);
        run_dump(a, n, "rnd_dump");
      end
    end

    // Reset in the middle of a read request.
    vld_pct = 100; rdy_pct = 100;
    pulse_start(1'b1, 12'o1000, 12'd3);
    wait_req(1'b0, "rst");
    resetn = 1'b0;
    #1;
    check("rst_async", 64'({mem_read_to_mem, busy, out_valid}), 64'd0);
    tick(); tick();
    resetn = 1'b1;
    tick();
    check("rst_idle", 64'({busy, sel_value_to_sel}), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
